// File: rtl/int_to_float.sv
// Multi-cycle signed 32-bit integer to IEEE-754 single converter.
// Normalizes by one left shift per cycle, then rounds and packs the result.
module int_to_float #(
  parameter int unsigned ROUND_MODE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] in_int,
  output logic [31:0] result,
  output logic        busy,
  output logic        done
);

  localparam int unsigned INT_W  = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 23;
  localparam logic [EXP_W-1:0] EXP_START = EXP_W'(127 + 31);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND
  } state_t;

  state_t              state;
  logic                sign;
  logic [INT_W-1:0]    mag;
  logic [EXP_W-1:0]    exp_q;

  logic [INT_W-1:0]    abs_in;
  logic [MANT_W-1:0]   mant;
  logic                guard;
  logic                sticky;
  logic                round_up;
  logic [MANT_W:0]     mant_sum;
  logic [EXP_W-1:0]    exp_rnd;

  // Two's-complement magnitude; the most negative value wraps to 2^31, which is exact.
  assign abs_in = in_int[INT_W-1] ? INT_W'(-in_int) : in_int;

  // Rounding of the normalized magnitude (hidden bit is mag[31]).
  assign mant     = mag[30:8];
  assign guard    = mag[7];
  assign sticky   = |mag[6:0];
  assign round_up = (ROUND_MODE != 0) && guard && (sticky || mant[0]);
  assign mant_sum = {1'b0, mant} + (MANT_W+1)'(round_up);
  assign exp_rnd  = exp_q + EXP_W'(mant_sum[MANT_W]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sign   <= 1'b0;
      mag    <= '0;
      exp_q  <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign  <= in_int[INT_W-1];
            mag   <= abs_in;
            exp_q <= EXP_START;
            busy  <= 1'b1;
            state <= NORM;
          end
        end
        NORM: begin
          if (mag == '0) begin
            // Zero converts to +0 regardless of the sampled sign.
            result <= '0;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else if (!mag[INT_W-1]) begin
            mag   <= {mag[INT_W-2:0], 1'b0};
            exp_q <= exp_q - EXP_W'(1);
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          // A carry out of the mantissa leaves it all-zero and bumps the exponent.
          result <= {sign, exp_rnd, mant_sum[MANT_W-1:0]};
          exp_q  <= exp_rnd;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_float.sv
// Scoreboard bench for int_to_float: stimulus pushes expected result and completion
// cycle into a queue, monitors pop and compare whenever done is seen.
module tb_int_to_float;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] in_int;
  logic [31:0] result;
  logic        busy;
  logic        done;

  logic        start_t;
  logic [31:0] in_int_t;
  logic [31:0] result_t;
  logic        busy_t;
  logic        done_t;

  int cycle;
  int pass_cnt;
  int total_cnt;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t q_t[$];

  int_to_float #(.ROUND_MODE(1)) dut (
    .clk(clk), .reset(reset), .start(start), .in_int(in_int),
    .result(result), .busy(busy), .done(done)
  );

  int_to_float #(.ROUND_MODE(0)) dut_trunc (
    .clk(clk), .reset(reset), .start(start_t), .in_int(in_int_t),
    .result(result_t), .busy(busy_t), .done(done_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cycle);
  endtask

  // Independent reference: exact real arithmetic with round-to-nearest-even.
  function automatic logic [31:0] model(input logic [31:0] v);
    real r, f, fl, rem;
    int e;
    int unsigned m;
    logic s;
    if (v == 32'h0) return 32'h0;
    s = v[31];
    r = $itor($signed(v));
    if (r < 0.0) r = -r;
    e = 0;
    while (r >= 2.0) begin
      r = r / 2.0;
      e++;
    end
    f   = (r - 1.0) * 8388608.0;
    fl  = $floor(f);
    rem = f - fl;
    m   = 32'($rtoi(fl));
    if (rem > 0.5 || (rem == 0.5 && m[0])) m++;
    if (m == 32'd8388608) begin
      m = 0;
      e++;
    end
    return {s, 8'(127 + e), m[22:0]};
  endfunction

  function automatic int latency_of(input logic [31:0] v);
    logic [31:0] mag;
    int lz;
    mag = v[31] ? 32'(-v) : v;
    if (mag == 32'h0) return 1;
    lz = 0;
    while (!mag[31]) begin
      mag = mag << 1;
      lz++;
    end
    return lz + 2;
  endfunction

  // Waits (bounded) at negedges until the converter is idle.
  task automatic wait_idle(input logic b_sel);
    int n;
    n = 0;
    while ((b_sel ? busy_t : busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total_cnt++;
      $display("FAIL wait_idle: busy still %0d after %0d cycles, want 0", 1, n);
    end
  endtask

  task automatic issue(input logic [31:0] v, input logic [31:0] res, input int lat);
    exp_t e;
    wait_idle(1'b0);
    e.res = res;
    e.due = cycle + 1 + lat;
    q.push_back(e);
    start  = 1'b1;
    in_int = v;
    @(negedge clk);
    start  = 1'b0;
    in_int = 32'hDEAD_BEEF;
  endtask

  task automatic issue_t(input logic [31:0] v, input logic [31:0] res, input int lat);
    exp_t e;
    wait_idle(1'b1);
    e.res = res;
    e.due = cycle + 1 + lat;
    q_t.push_back(e);
    start_t  = 1'b1;
    in_int_t = v;
    @(negedge clk);
    start_t  = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      check("busy_with_done", 32'(busy), 32'h0);
      if (q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_done: got done with result %h, want no done", result);
      end else begin
        e = q.pop_front();
        check("result", result, e.res);
        check("latency", 32'(cycle), 32'(e.due));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && done_t) begin
      if (q_t.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_done_trunc: got result %h, want no done", result_t);
      end else begin
        e = q_t.pop_front();
        check("result_trunc", result_t, e.res);
        check("latency_trunc", 32'(cycle), 32'(e.due));
      end
    end
  end

  initial begin
    logic [31:0] v;
    int n;
    cycle     = 0;
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b1;
    start     = 1'b0;
    in_int    = 32'h0;
    start_t   = 1'b0;
    in_int_t  = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_result", result, 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors with hand-computed results and latencies.
    issue(32'h0000_0001, 32'h3F80_0000, 33);
    check("busy_after_start", 32'(busy), 32'h1);
    issue(32'hFFFF_FFFF, 32'hBF80_0000, 33);
    issue(32'h0000_0000, 32'h0000_0000, 1);
    issue(32'h8000_0000, 32'hCF00_0000, 2);
    issue(32'h7FFF_FFFF, 32'h4F00_0000, 3);
    issue(32'h0100_0001, 32'h4B80_0000, 9);
    issue(32'h0100_0003, 32'h4B80_0002, 9);
    issue(32'hFFFF_FFFB, 32'hC0A0_0000, 31);

    issue_t(32'h0100_0003, 32'h4B80_0001, 9);
    issue_t(32'h7FFF_FFFF, 32'h4EFF_FFFF, 3);

    // A start pulse mid-conversion must be ignored.
    issue(32'h0000_0001, 32'h3F80_0000, 33);
    repeat (3) @(negedge clk);
    start  = 1'b1;
    in_int = 32'h1234_5678;
    @(negedge clk);
    start  = 1'b0;
    check("busy_mid", 32'(busy), 32'h1);
    // The next issue lands in the done cycle: back-to-back conversion.
    issue(32'h0100_0003, 32'h4B80_0002, 9);
    issue(32'h0000_0000, 32'h0000_0000, 1);
    issue(32'h8000_0000, 32'hCF00_0000, 2);

    // Reset during NORM aborts without a done.
    wait_idle(1'b0);
    start  = 1'b1;
    in_int = 32'h0000_0001;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_result", result, 32'h0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_idle", 32'(busy), 32'h0);
    issue(32'h0000_0001, 32'h3F80_0000, 33);

    // Random operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      case (i % 3)
        0:       v = $urandom;
        1:       v = 32'($urandom_range(0, 1000));
        default: v = -32'($urandom_range(1, 70000));
      endcase
      issue(v, model(v), latency_of(v));
    end

    n = 0;
    while ((q.size() != 0 || q_t.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || q_t.size() != 0) begin
      total_cnt++;
      $display("FAIL drain: got %0d pending results, want 0", q.size() + q_t.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
